rd_ptr_ctrl: RTL and testbench

Read-side pointer and status controller for the asynchronous FIFO, running entirely in the read clock domain. It owns the read pointer in binary and Gray form and resynchronises the write-domain Gray pointer through a two-flop synchroniser. From those it produces registered empty, almost-empty, occupancy and underflow-error outputs. It pairs with the write-side count logic: the write side consumes `rptr_gray_o`, and this block consumes the write side's Gray pointer.

---
 rtl/async_fifo_pkg.sv | 35 +++
 rtl/rd_ptr_ctrl_if.sv | 46 ++++
 rtl/sync_2ff.sv | 37 +++
 rtl/rd_ptr_ctrl.sv | 88 ++++++++
 tb/tb_rd_ptr_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared definitions for both halves of the asynchronous FIFO.
//   - ptr_width()   : pointer width from RAM address width (one extra wrap bit)
//   - bin2gray()    : binary -> Gray
//   - gray2bin()    : Gray -> binary
//   The conversions work on a wide word. Callers zero-extend their pointer
//   into it and truncate the result back. Leading zeros are neutral for both
//   conversions, so one function body serves every pointer width.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int WRAP_BITS = 1;
  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_word_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + WRAP_BITS;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = gray[i] ^ bin[i+1];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// rd_ptr_ctrl_if
//   Read-side FIFO status bundle.
//   master : consumer / write-side view (drives rd_en_i, wptr_gray_i)
//   slave  : rd_ptr_ctrl view (drives the pointer and status outputs)
//   Signals:
//     rd_en_i      read request
//     wptr_gray_i  write pointer in Gray code, write-clock domain
//     raddr_o      RAM read address
//     rptr_bin_o   binary read pointer
//     rptr_gray_o  Gray read pointer, sent to the write domain
//     rd_empty_o   FIFO empty
//     rd_aempty_o  occupancy <= almost-empty threshold
//     rd_cnt_o     entries available to read
//     rd_err_o     one-cycle pulse on a read attempt while empty
// -----------------------------------------------------------------------------
interface rd_ptr_ctrl_if
  import async_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = 5
);
  localparam int PW = ptr_width(PTR_WIDTH);

  logic                 rd_en_i;
  logic [PW-1:0]        wptr_gray_i;
  logic [PTR_WIDTH-1:0] raddr_o;
  logic [PW-1:0]        rptr_bin_o;
  logic [PW-1:0]        rptr_gray_o;
  logic                 rd_empty_o;
  logic                 rd_aempty_o;
  logic [PW-1:0]        rd_cnt_o;
  logic                 rd_err_o;

  modport master (
    output rd_en_i, wptr_gray_i,
    input  raddr_o, rptr_bin_o, rptr_gray_o,
    input  rd_empty_o, rd_aempty_o, rd_cnt_o, rd_err_o
  );

  modport slave (
    input  rd_en_i, wptr_gray_i,
    output raddr_o, rptr_bin_o, rptr_gray_o,
    output rd_empty_o, rd_aempty_o, rd_cnt_o, rd_err_o
  );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchroniser for a Gray-coded bus crossing into the
//   rd_clk_i domain. Only q_o (second stage) may be used downstream.
//   Ports:
//     rd_clk_i  destination clock
//     rstn_i    asynchronous active-low reset, clears both stages
//     d_i       asynchronous input bus
//     q_o       synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             rd_clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge rd_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= d_i;
      stage2 <= stage1;
    end
  end

  assign q_o = stage2;

endmodule

// File: rtl/rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// rd_ptr_ctrl
//   Read-side pointer and status controller of the asynchronous FIFO. Owns the
//   read pointer (binary and Gray), resynchronises the write Gray pointer and
//   produces registered empty / almost-empty / count / underflow outputs.
//   Ports:
//     rd_clk_i  read clock, the only clock of this block
//     rstn_i    asynchronous active-low reset
//     bus       rd_ptr_ctrl_if.slave (request in, pointers and status out)
//   Status is computed from the next-state read pointer, so a read updates
//   empty/count on the same edge. The write pointer is seen through the
//   synchroniser and lags, so status can only be pessimistic.
// -----------------------------------------------------------------------------
module rd_ptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = 5,
  parameter int AEMPTY_TH = 2
) (
  input  logic         rd_clk_i,
  input  logic         rstn_i,
  rd_ptr_ctrl_if.slave bus
);

  localparam int PW = ptr_width(PTR_WIDTH);
  localparam logic [PW-1:0] AEMPTY_LIM = PW'(AEMPTY_TH);

  logic [PW-1:0] wp2rp_gray;
  logic [PW-1:0] wptr_bin_s;
  logic          rd_fire;
  logic [PW-1:0] rptr_bin_nxt;
  logic [PW-1:0] rptr_gray_nxt;
  logic [PW-1:0] occ_nxt;

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_gray;
  logic          rd_empty;
  logic          rd_aempty;
  logic [PW-1:0] rd_cnt;
  logic          rd_err;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .rd_clk_i (rd_clk_i),
    .rstn_i   (rstn_i),
    .d_i      (bus.wptr_gray_i),
    .q_o      (wp2rp_gray)
  );

  // NOTE: every signal driven here gets a value on every path (no if without
  // else), so no latches are inferred.
  always_comb begin
    wptr_bin_s    = PW'(gray2bin(ptr_word_t'(wp2rp_gray)));
    rd_fire       = bus.rd_en_i & ~rd_empty;
    // Natural modulo-2^PW wrap flips the MSB when crossing all-ones -> 0.
    rptr_bin_nxt  = rptr_bin + {{(PW-1){1'b0}}, rd_fire};
    rptr_gray_nxt = PW'(bin2gray(ptr_word_t'(rptr_bin_nxt)));
    // Modulo subtraction: range 0..2^PTR_WIDTH because the wrap bit is kept.
    occ_nxt       = wptr_bin_s - rptr_bin_nxt;
  end

  always_ff @(posedge rd_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      rd_empty  <= 1'b1;
      rd_aempty <= 1'b1;
      rd_cnt    <= '0;
      rd_err    <= 1'b0;
    end else begin
      rptr_bin  <= rptr_bin_nxt;
      rptr_gray <= rptr_gray_nxt;
      // Full-width compare: a full FIFO differs in the wrap bit, not empty.
      rd_empty  <= (rptr_gray_nxt == wp2rp_gray);
      rd_aempty <= (occ_nxt <= AEMPTY_LIM);
      rd_cnt    <= occ_nxt;
      rd_err    <= bus.rd_en_i & rd_empty;
    end
  end

  assign bus.raddr_o     = rptr_bin[PTR_WIDTH-1:0];
  assign bus.rptr_bin_o  = rptr_bin;
  assign bus.rptr_gray_o = rptr_gray;
  assign bus.rd_empty_o  = rd_empty;
  assign bus.rd_aempty_o = rd_aempty;
  assign bus.rd_cnt_o    = rd_cnt;
  assign bus.rd_err_o    = rd_err;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rd_ptr_ctrl
//   Directed bench for rd_ptr_ctrl (PTR_WIDTH=5, AEMPTY_TH=2). Inputs change
//   and outputs are sampled on the falling edge; the DUT acts on rising edges.
// -----------------------------------------------------------------------------
module tb_rd_ptr_ctrl;

  logic clk;
  logic rstn;

  int n_vec;
  int n_err;

  rd_ptr_ctrl_if #(.PTR_WIDTH(5)) bus ();

  rd_ptr_ctrl #(
    .PTR_WIDTH (5),
    .AEMPTY_TH (2)
  ) dut (
    .rd_clk_i (clk),
    .rstn_i   (rstn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One active edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] tg(input int b);
    logic [5:0] v;
    v = b[5:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_vals(input string sect);
    check({sect, "_raddr"},  32'(bus.raddr_o),     0);
    check({sect, "_rbin"},   32'(bus.rptr_bin_o),  0);
    check({sect, "_rgray"},  32'(bus.rptr_gray_o), 0);
    check({sect, "_empty"},  32'(bus.rd_empty_o),  1);
    check({sect, "_aempty"}, 32'(bus.rd_aempty_o), 1);
    check({sect, "_cnt"},    32'(bus.rd_cnt_o),    0);
    check({sect, "_err"},    32'(bus.rd_err_o),    0);
  endtask

  initial begin
    logic [5:0] prev_gray;
    n_vec = 0;
    n_err = 0;

    // ---------------- reset with random inputs ----------------
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_en_i     = 1'($urandom_range(0, 1));
      bus.wptr_gray_i = 6'($urandom);
      step();
    end
    check_reset_vals("rst");

    bus.rd_en_i     = 1'b0;
    bus.wptr_gray_i = 6'd0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset_vals("post_rst");

    // ---------------- sync latency: 0 -> gray(3) ----------------
    bus.wptr_gray_i = 6'b000010;
    step();  // E
    check("lat_e_cnt", 32'(bus.rd_cnt_o), 0);
    check("lat_e_empty", 32'(bus.rd_empty_o), 1);
    step();  // E+1
    check("lat_e1_cnt", 32'(bus.rd_cnt_o), 0);
    check("lat_e1_empty", 32'(bus.rd_empty_o), 1);
    check("lat_e1_aempty", 32'(bus.rd_aempty_o), 1);
    step();  // E+2
    check("lat_e2_cnt", 32'(bus.rd_cnt_o), 3);
    check("lat_e2_empty", 32'(bus.rd_empty_o), 0);
    check("lat_e2_aempty", 32'(bus.rd_aempty_o), 0);

    // ---------------- drain 3 entries, 4th request underflows ----------------
    begin
      int exp_addr [4]  = '{1, 2, 3, 3};
      int exp_cnt [4]   = '{2, 1, 0, 0};
      int exp_empty [4] = '{0, 0, 1, 1};
      int exp_aemp [4]  = '{1, 1, 1, 1};
      int exp_err [4]   = '{0, 0, 0, 1};
      bus.rd_en_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("drain%0d_raddr", i), 32'(bus.raddr_o), exp_addr[i]);
        check($sformatf("drain%0d_cnt", i), 32'(bus.rd_cnt_o), exp_cnt[i]);
        check($sformatf("drain%0d_empty", i), 32'(bus.rd_empty_o), exp_empty[i]);
        check($sformatf("drain%0d_aempty", i), 32'(bus.rd_aempty_o), exp_aemp[i]);
        check($sformatf("drain%0d_err", i), 32'(bus.rd_err_o), exp_err[i]);
      end
      bus.rd_en_i = 1'b0;
      step();
      check("drain_err_clear", 32'(bus.rd_err_o), 0);
      check("drain_ptr_hold", 32'(bus.rptr_bin_o), 3);
    end

    // ---------------- full occupancy: wptr = gray(32), rptr = 0 ----------------
    rstn = 1'b0;
    step();
    check_reset_vals("rst2");
    rstn = 1'b1;
    bus.wptr_gray_i = 6'b110000;
    for (int i = 0; i < 3; i++) step();
    check("full_cnt", 32'(bus.rd_cnt_o), 32);
    check("full_empty", 32'(bus.rd_empty_o), 0);
    check("full_aempty", 32'(bus.rd_aempty_o), 0);

    // ---------------- read all 32, crossing 31 -> 32 ----------------
    bus.rd_en_i = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("rd32_%0d_rbin", i), 32'(bus.rptr_bin_o), 32'(i));
      check($sformatf("rd32_%0d_cnt", i), 32'(bus.rd_cnt_o), 32'(32 - i));
    end
    check("wrap32_msb", 32'(bus.rptr_bin_o[5]), 1);
    check("wrap32_raddr", 32'(bus.raddr_o), 0);
    check("wrap32_gray", 32'(bus.rptr_gray_o), 32'(tg(32)));
    check("wrap32_empty", 32'(bus.rd_empty_o), 1);

    // ---------------- simultaneous read+write, crossing 63 -> 0 ----------------
    bus.rd_en_i     = 1'b0;
    bus.wptr_gray_i = tg(36);
    for (int i = 0; i < 3; i++) step();
    check("sim_pre_cnt", 32'(bus.rd_cnt_o), 4);
    prev_gray = bus.rptr_gray_o;
    for (int j = 0; j <= 32; j++) begin
      bus.wptr_gray_i = tg(37 + j);
      bus.rd_en_i     = 1'b1;
      step();
      check($sformatf("sim%0d_rbin", j), 32'(bus.rptr_bin_o), 32'((33 + j) % 64));
      check($sformatf("sim%0d_raddr", j), 32'(bus.raddr_o), 32'((33 + j) % 32));
      check($sformatf("sim%0d_gray", j), 32'(bus.rptr_gray_o), 32'(tg(33 + j)));
      check($sformatf("sim%0d_gray1bit", j), 32'($countones(prev_gray ^ bus.rptr_gray_o)), 1);
      check($sformatf("sim%0d_empty", j), 32'(bus.rd_empty_o), 0);
      check($sformatf("sim%0d_cnt", j), 32'(bus.rd_cnt_o), (j == 0) ? 3 : 2);
      prev_gray = bus.rptr_gray_o;
    end
    bus.rd_en_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("post_wrap_rbin", 32'(bus.rptr_bin_o), 1);
    check("post_wrap_cnt", 32'(bus.rd_cnt_o), 4);
    check("post_wrap_aempty", 32'(bus.rd_aempty_o), 0);

    // ---------------- reset mid-stream, between clock edges ----------------
    bus.rd_en_i = 1'b1;
    step();
    step();
    check("mid_rbin", 32'(bus.rptr_bin_o), 3);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    bus.rd_en_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
